reset_signal_tx: RTL and testbench

Parametrised transmitter for Hard Reset and Cable Reset ordered sets in the TCPC transmit path. It arbitrates between the two request types, with Hard Reset taking priority. It drives the PHY request and `transmit` code, supervises completion with a programmable timeout and a bounded retry count, and issues single-cycle success or failure alerts to the ALERT register logic. It replaces the fixed-width, single-attempt reset transmitter and adds retries, preemption and a dropped-request indication.

---
 rtl/reset_signal_tx.sv | 124 ++++++++++++
 tb/tb_reset_signal_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_signal_tx.sv
// Hard Reset / Cable Reset ordered-set transmitter: arbitration, PHY handshake,
// per-attempt timeout with bounded retries, preemption and single-cycle alerts.
module reset_signal_tx #(
   parameter int TIMER_W = 16,
   parameter int RETRY_W = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               hard_reset_req,
   input  logic               cable_reset_req,
   input  logic [TIMER_W-1:0] timeout_cycles,
   input  logic [RETRY_W-1:0] max_retries,
   input  logic               phy_ack,
   output logic [2:0]         transmit,
   output logic               phy_request,
   output logic               alert_tx_success,
   output logic               alert_tx_failed,
   output logic               req_dropped,
   output logic               busy,
   output logic [RETRY_W-1:0] retry_count
);

   typedef enum logic [1:0] {IDLE, WAIT, GAP, DONE} state_e;

   localparam logic [2:0] TX_IDLE  = 3'b000;
   localparam logic [2:0] TX_HARD  = 3'b101;
   localparam logic [2:0] TX_CABLE = 3'b110;

   state_e             state_q;
   logic [TIMER_W-1:0] timer_q;
   logic [RETRY_W-1:0] max_q;
   logic [RETRY_W-1:0] retry_q;
   logic [2:0]         tx_q;
   logic               preq_q;
   logic               succ_q;
   logic               fail_q;
   logic               drop_q;
   logic               busy_q;
   logic               active;
   logic               preempt;

   assign active  = (state_q == WAIT) || (state_q == GAP);
   // A Hard Reset request aborts an in-flight Cable Reset and restarts from scratch.
   assign preempt = active && hard_reset_req && (tx_q == TX_CABLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         max_q   <= '0;
         retry_q <= '0;
         tx_q    <= TX_IDLE;
         preq_q  <= 1'b0;
         succ_q  <= 1'b0;
         fail_q  <= 1'b0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         succ_q <= 1'b0;
         fail_q <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hard_reset_req || cable_reset_req) begin
                  state_q <= WAIT;
                  tx_q    <= hard_reset_req ? TX_HARD : TX_CABLE;
                  timer_q <= timeout_cycles;
                  retry_q <= '0;
                  max_q   <= max_retries;
                  preq_q  <= 1'b1;
                  busy_q  <= 1'b1;
                  drop_q  <= hard_reset_req && cable_reset_req;
               end
            end
            WAIT, GAP: begin
               drop_q <= cable_reset_req || (hard_reset_req && (tx_q == TX_HARD));
               if (preempt) begin
                  state_q <= WAIT;
                  tx_q    <= TX_HARD;
                  timer_q <= timeout_cycles;
                  retry_q <= '0;
                  max_q   <= max_retries;
                  preq_q  <= 1'b1;
               end else if (state_q == GAP) begin
                  state_q <= WAIT;
                  timer_q <= timeout_cycles;
                  preq_q  <= 1'b1;
               end else if (phy_ack) begin
                  state_q <= DONE;
                  preq_q  <= 1'b0;
                  succ_q  <= 1'b1;
               end else if (timer_q == '0) begin
                  preq_q <= 1'b0;
                  if (retry_q < max_q) begin
                     state_q <= GAP;
                     retry_q <= retry_q + 1'b1;
                  end else begin
                     state_q <= DONE;
                     fail_q  <= 1'b1;
                  end
               end else begin
                  timer_q <= timer_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               tx_q    <= TX_IDLE;
               busy_q  <= 1'b0;
               drop_q  <= hard_reset_req || cable_reset_req;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign transmit         = tx_q;
   assign phy_request      = preq_q;
   assign alert_tx_success = succ_q;
   assign alert_tx_failed  = fail_q;
   assign req_dropped      = drop_q;
   assign busy             = busy_q;
   assign retry_count      = retry_q;

endmodule

// File: tb/tb_reset_signal_tx.sv
// Bench for reset_signal_tx: directed scenarios, a positional behavioural model
// compared every cycle, and literal expectations per scenario.
module tb_reset_signal_tx;

   localparam int TIMER_W = 16;
   localparam int RETRY_W = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               hard_reset_req = 1'b0;
   logic               cable_reset_req = 1'b0;
   logic [TIMER_W-1:0] timeout_cycles = '0;
   logic [RETRY_W-1:0] max_retries = '0;
   logic               phy_ack = 1'b0;
   logic [2:0]         transmit;
   logic               phy_request;
   logic               alert_tx_success;
   logic               alert_tx_failed;
   logic               req_dropped;
   logic               busy;
   logic [RETRY_W-1:0] retry_count;

   int checks = 0;
   int failures = 0;
   int n_preq = 0, n_succ = 0, n_fail = 0, n_drop = 0, n_gap = 0;

   reset_signal_tx #(.TIMER_W(TIMER_W), .RETRY_W(RETRY_W)) dut (
      .clk(clk), .reset(reset),
      .hard_reset_req(hard_reset_req), .cable_reset_req(cable_reset_req),
      .timeout_cycles(timeout_cycles), .max_retries(max_retries), .phy_ack(phy_ack),
      .transmit(transmit), .phy_request(phy_request),
      .alert_tx_success(alert_tx_success), .alert_tx_failed(alert_tx_failed),
      .req_dropped(req_dropped), .busy(busy), .retry_count(retry_count)
   );

   always #5 clk = ~clk;

   // Model: position p counts cycles since the operation (re)started; each
   // attempt occupies T+1 WAIT cycles followed by one GAP cycle.
   bit m_act = 0, m_done = 0, m_succ = 0, m_fail = 0, m_drop = 0;
   int m_code = 0, m_T = 0, m_R = 0, m_p = 0, m_retry = 0;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_act = 0; m_done = 0; m_succ = 0; m_fail = 0; m_drop = 0;
         m_code = 0; m_T = 0; m_R = 0; m_p = 0; m_retry = 0;
      end else begin
         int per, o, k;
         bit h, c, a;
         h = hard_reset_req; c = cable_reset_req; a = phy_ack;
         m_succ = 0; m_fail = 0; m_drop = 0;
         if (!m_act) begin
            if (h || c) begin
               m_act = 1; m_done = 0; m_p = 0; m_retry = 0;
               m_code = h ? 5 : 6;
               m_T = int'(timeout_cycles); m_R = int'(max_retries);
               m_drop = h && c;
            end
         end else if (m_done) begin
            m_act = 0; m_done = 0; m_code = 0;
            m_drop = h || c;
         end else begin
            per = m_T + 2; o = m_p % per; k = m_p / per;
            m_drop = c || (h && m_code == 5);
            if (h && m_code == 6) begin
               m_code = 5; m_p = 0;
               m_T = int'(timeout_cycles); m_R = int'(max_retries);
            end else if (o > m_T) begin
               m_p++;
            end else if (a) begin
               m_done = 1; m_succ = 1; m_retry = k;
            end else if (o == m_T && k >= m_R) begin
               m_done = 1; m_fail = 1; m_retry = k;
            end else begin
               m_p++;
            end
         end
      end
   end

   initial forever begin
      int e_tx, e_preq, e_retry;
      @(posedge clk);
      #2;
      e_tx    = m_act ? m_code : 0;
      e_preq  = (m_act && !m_done && ((m_p % (m_T + 2)) <= m_T)) ? 1 : 0;
      e_retry = (m_act && !m_done) ? (m_p + 1) / (m_T + 2) : m_retry;
      checks++;
      if (int'(transmit) !== e_tx || int'(phy_request) !== e_preq ||
          alert_tx_success !== m_succ || alert_tx_failed !== m_fail ||
          req_dropped !== m_drop || busy !== m_act || int'(retry_count) !== e_retry) begin
         failures++;
         $display("FAIL model_cmp t=%0t got tx=%0d preq=%0b ok=%0b fail=%0b drop=%0b busy=%0b retry=%0d expected tx=%0d preq=%0d ok=%0b fail=%0b drop=%0b busy=%0b retry=%0d",
                  $time, transmit, phy_request, alert_tx_success, alert_tx_failed, req_dropped, busy, retry_count,
                  e_tx, e_preq, m_succ, m_fail, m_drop, m_act, e_retry);
      end
      if (phy_request) n_preq++;
      if (alert_tx_success) n_succ++;
      if (alert_tx_failed) n_fail++;
      if (req_dropped) n_drop++;
      if (busy && !phy_request && !alert_tx_success && !alert_tx_failed) n_gap++;
   end

   task automatic drive(input logic h, input logic c, input logic a);
      @(negedge clk);
      hard_reset_req = h; cable_reset_req = c; phy_ack = a;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clr_counts();
      n_preq = 0; n_succ = 0; n_fail = 0; n_drop = 0; n_gap = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle(3);
      chk("rst_transmit", int'(transmit), 0);
      chk("rst_phy_request", int'(phy_request), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_retry", int'(retry_count), 0);
      chk("rst_alerts", int'({alert_tx_success, alert_tx_failed, req_dropped}), 0);
      reset = 1'b0;
      idle(2);

      // Hard Reset acknowledged on the third WAIT cycle.
      timeout_cycles = 16'd10; max_retries = 2'd1; clr_counts();
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t1_transmit", int'(transmit), 5);
      chk("t1_preq", int'(phy_request), 1);
      chk("t1_busy", int'(busy), 1);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0);
      chk("t1_success", int'(alert_tx_success), 1);
      chk("t1_preq_done", int'(phy_request), 0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t1_idle_busy", int'(busy), 0);
      chk("t1_idle_tx", int'(transmit), 0);
      chk("t1_preq_cnt", n_preq, 3);
      chk("t1_succ_cnt", n_succ, 1);
      chk("t1_retry", int'(retry_count), 0);

      // Cable Reset with two retries and no acknowledge.
      timeout_cycles = 16'd4; max_retries = 2'd2; clr_counts();
      drive(1'b0, 1'b1, 1'b0);
      idle(18);
      chk("t2_fail", int'(alert_tx_failed), 1);
      chk("t2_retry", int'(retry_count), 2);
      chk("t2_tx_done", int'(transmit), 6);
      drive(1'b0, 1'b0, 1'b0);
      chk("t2_tx_idle", int'(transmit), 0);
      chk("t2_preq_cnt", n_preq, 15);
      chk("t2_gap_cnt", n_gap, 2);
      chk("t2_fail_cnt", n_fail, 1);
      chk("t2_succ_cnt", n_succ, 0);

      // Cable Reset preempted by Hard Reset on its second WAIT cycle.
      clr_counts();
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t3_tx_hard", int'(transmit), 5);
      chk("t3_retry", int'(retry_count), 0);
      chk("t3_preq", int'(phy_request), 1);
      idle(2);
      drive(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("t3_succ_cnt", n_succ, 1);
      chk("t3_fail_cnt", n_fail, 0);

      // Simultaneous requests, then redundant requests during a Hard Reset.
      timeout_cycles = 16'd10; clr_counts();
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t4_tx", int'(transmit), 5);
      chk("t4_drop_both", int'(req_dropped), 1);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t4_drop_cable", int'(req_dropped), 1);
      chk("t4_tx_kept", int'(transmit), 5);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      chk("t4_drop_hard", int'(req_dropped), 1);
      idle(3);
      chk("t4_drop_cnt", n_drop, 3);
      chk("t4_succ_cnt", n_succ, 1);

      // Ack on the expiry cycle wins; a request during DONE is dropped.
      timeout_cycles = 16'd2; max_retries = 2'd1; clr_counts();
      drive(1'b1, 1'b0, 1'b0);
      idle(2);
      drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b0);
      chk("t5_success", int'(alert_tx_success), 1);
      chk("t5_retry", int'(retry_count), 0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t5_done_drop", int'(req_dropped), 1);
      chk("t5_busy", int'(busy), 0);
      chk("t5_fail_cnt", n_fail, 0);

      // Zero timeout, zero retries: single WAIT cycle then failure.
      timeout_cycles = 16'd0; max_retries = 2'd0; clr_counts();
      drive(1'b0, 1'b1, 1'b0);
      idle(2);
      chk("t5b_fail", int'(alert_tx_failed), 1);
      idle(2);
      chk("t5b_preq_cnt", n_preq, 1);
      chk("t5b_fail_cnt", n_fail, 1);

      // Asynchronous reset during the GAP of a retrying Cable Reset.
      timeout_cycles = 16'd3; max_retries = 2'd2; clr_counts();
      drive(1'b0, 1'b1, 1'b0);
      idle(5);
      chk("t6_gap_preq", int'(phy_request), 0);
      chk("t6_gap_retry", int'(retry_count), 1);
      chk("t6_gap_busy", int'(busy), 1);
      #2 reset = 1'b1;
      #1;
      chk("t6_rst_outputs", int'({transmit, phy_request, alert_tx_success, alert_tx_failed,
                                  req_dropped, busy, retry_count}), 0);
      idle(2);
      reset = 1'b0;
      idle(3);
      chk("t6_no_alert", n_succ + n_fail, 0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t6_new_retry", int'(retry_count), 0);
      chk("t6_new_tx", int'(transmit), 5);
      drive(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("t6_new_succ", n_succ, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
